// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate divider, horizontal/vertical counters,
// registered active-low sync outputs and a frame-start pulse.
module vga_sync_gen #(
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] pixelx,
    output logic [9:0] pixely,
    output logic       p_tick,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_LAST  = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_LAST  = V_DISPLAY + V_FRONT + V_SYNC - 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pixelx_q, pixelx_d;
    logic [CNT_W-1:0] pixely_q, pixely_d;
    logic             p_tick_q, p_tick_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;
    logic             line_end, frame_end;

    // Next-state: syncs are decoded from next counts so they move with them.
    always_comb begin
        div_d         = div_q;
        pixelx_d      = pixelx_q;
        pixely_d      = pixely_q;
        frame_start_d = 1'b0;
        line_end      = (pixelx_q == CNT_W'(H_TOTAL - 1));
        frame_end     = (pixely_q == CNT_W'(V_TOTAL - 1));

        if (div_q == DIV_W'(TICK_DIV - 1)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        p_tick_d = (div_d == DIV_W'(TICK_DIV - 1));

        if (p_tick_q) begin
            if (line_end) begin
                pixelx_d = '0;
                if (frame_end) begin
                    pixely_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    pixely_d = pixely_q + CNT_W'(1);
                end
            end else begin
                pixelx_d = pixelx_q + CNT_W'(1);
            end
        end

        hsync_d = !((pixelx_d >= CNT_W'(HS_FIRST)) && (pixelx_d <= CNT_W'(HS_LAST)));
        vsync_d = !((pixely_d >= CNT_W'(VS_FIRST)) && (pixely_d <= CNT_W'(VS_LAST)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            pixelx_q      <= '0;
            pixely_q      <= '0;
            p_tick_q      <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pixelx_q      <= pixelx_d;
            pixely_q      <= pixely_d;
            p_tick_q      <= p_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixelx      = pixelx_q;
    assign pixely      = pixely_q;
    assign p_tick      = p_tick_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    // Derived straight from the registered counts so it lines up with pixelx/pixely.
    assign video_on    = (pixelx_q < CNT_W'(H_DISPLAY)) && (pixely_q < CNT_W'(V_DISPLAY));

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance plus a shrunken-geometry
// instance so whole frames and wraps fit in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic [9:0] d_px, d_py, s_px, s_py;
    logic       d_pt, d_vo, d_hs, d_vs, d_fs;
    logic       s_pt, s_vo, s_hs, s_vs, s_fs;

    int unsigned n;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    vga_sync_gen dut (
        .clk(clk), .reset_n(reset_n), .pixelx(d_px), .pixely(d_py), .p_tick(d_pt),
        .video_on(d_vo), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
    );

    vga_sync_gen #(
        .TICK_DIV(4), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .pixelx(s_px), .pixely(s_py), .p_tick(s_pt),
        .video_on(s_vo), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s n=%0d: observed %0d expected %0d", tag, n, obs, exp);
        end
    endtask

    // Reference: everything follows from n, the number of edges since reset release.
    task automatic check_inst(input string tag,
                              input int unsigned hd, hf, hs, hb, vd, vf, vs, vb,
                              input logic [9:0] ox, oy,
                              input logic opt, ovo, ohs, ovs, ofs);
        int unsigned ht, vt, t, ex, ey;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        t  = n / 4;
        ex = t % ht;
        ey = (t / ht) % vt;
        check({tag, "_px"}, 32'(ox), ex);
        check({tag, "_py"}, 32'(oy), ey);
        check({tag, "_ptick"}, 32'(opt), 32'((n % 4) == 3));
        check({tag, "_video"}, 32'(ovo), 32'((ex < hd) && (ey < vd)));
        check({tag, "_hsync"}, 32'(ohs), 32'(!((ex >= hd + hf) && (ex < hd + hf + hs))));
        check({tag, "_vsync"}, 32'(ovs), 32'(!((ey >= vd + vf) && (ey < vd + vf + vs))));
        check({tag, "_fstart"}, 32'(ofs), 32'((n > 0) && (n % 4 == 0) && (t % (ht * vt) == 0)));
    endtask

    task automatic check_all();
        check_inst("dflt", 640, 16, 96, 48, 480, 10, 2, 33, d_px, d_py, d_pt, d_vo, d_hs, d_vs, d_fs);
        check_inst("small", 16, 4, 6, 4, 8, 2, 2, 3, s_px, s_py, s_pt, s_vo, s_hs, s_vs, s_fs);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset_n) n++;
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_px"}, 32'(d_px), 0);
        check({tag, "_py"}, 32'(d_py), 0);
        check({tag, "_hs"}, 32'(d_hs), 1);
        check({tag, "_vs"}, 32'(d_vs), 1);
        check({tag, "_pt"}, 32'(d_pt), 0);
        check({tag, "_fs"}, 32'(d_fs), 0);
        check({tag, "_vo"}, 32'(d_vo), 1);
        check({tag, "_spx"}, 32'(s_px), 0);
        check({tag, "_shs"}, 32'(s_hs), 1);
    endtask

    initial begin
        int unsigned fs_count, vo_count, max_sx, max_sy, target;

        // Reset state
        n = 0;
        reset_n = 1'b0;
        repeat (3) step();
        check_reset_values("reset");

        // Release and run two full default lines; the small raster wraps several frames.
        @(negedge clk);
        reset_n = 1'b1;
        fs_count = 0;
        vo_count = 0;
        max_sx = 0;
        max_sy = 0;
        while (n < 6640) begin
            step();
            if (n == 40) begin
                check("px_after_40", 32'(d_px), 10);
                check("py_after_40", 32'(d_py), 0);
            end
            if (n == 4 * 656 - 1) check("hs_before_fall", 32'(d_hs), 1);
            if (n == 4 * 656)     check("hs_at_656", 32'(d_hs), 0);
            if (n == 4 * 752 - 1) check("hs_before_rise", 32'(d_hs), 0);
            if (n == 4 * 752)     check("hs_at_752", 32'(d_hs), 1);
            if (n == 4 * 640)     check("vo_at_640_0", 32'(d_vo), 0);
            if (s_fs) fs_count++;
            if (n <= 1800 && s_vo) vo_count++;
            if (32'(s_px) > max_sx) max_sx = 32'(s_px);
            if (32'(s_py) > max_sy) max_sy = 32'(s_py);
        end
        check("small_frame_starts", fs_count, 3);
        check("small_video_clks", vo_count, 16 * 8 * 4);
        check("small_max_px", max_sx, 29);
        check("small_max_py", max_sy, 14);

        // Mid-line asynchronous resets, first inside default hsync, then inside small hsync.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset_n = 1'b0;
            #1;
            n = 0;
            repeat (2) step();
            @(negedge clk);
            reset_n = 1'b1;
            if (i == 0) target = 4 * 700 + $urandom_range(0, 3);
            else target = 4 * (30 * $urandom_range(0, 14) + $urandom_range(20, 25)) + $urandom_range(0, 3);
            while (n < target) step();
            if (i == 0) check("pre_rst_dflt_hs", 32'(d_hs), 0);
            else check("pre_rst_small_hs", 32'(s_hs), 0);
            #2;
            reset_n = 1'b0;
            #1;
            check_reset_values("async_rst");
        end

        // Restart after the last reset follows the same timing as the first release.
        n = 0;
        repeat (2) step();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) step();
        check("px_after_40_restart", 32'(d_px), 10);
        check("py_after_40_restart", 32'(d_py), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
